// File: rtl/vga_pkg.sv
// Shared colour constants, palette and mode encodings for the VGA pattern generator.
package vga_pkg;

  localparam int PIX_W = 12;
  typedef logic [PIX_W-1:0] color_t;

  localparam color_t BLACK   = 12'h000;
  localparam color_t WHITE   = 12'hFFF;
  localparam color_t RED     = 12'hF00;
  localparam color_t YELLOW  = 12'hFF0;
  localparam color_t GREEN   = 12'h0F0;
  localparam color_t CYAN    = 12'h0FF;
  localparam color_t BLUE    = 12'h00F;
  localparam color_t MAGENTA = 12'hF0F;

  // Classic SMPTE-style bar order, also used as the cycle-mode sequence.
  localparam color_t PALETTE [0:7] = '{WHITE, YELLOW, CYAN, GREEN, MAGENTA, RED, BLUE, BLACK};

  localparam logic [1:0] MODE_SOLID = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_CYCLE = 2'd3;

endpackage

// File: rtl/vga_frame_stepper.sv
// Frame boundary detect, registered frame_tick, and the cycle-mode frame/colour counters.
module vga_frame_stepper #(
  parameter int V_ACTIVE        = 480,
  parameter int FRAMES_PER_STEP = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hCount,
  input  logic [10:0] vCount,
  input  logic        run,
  input  logic        enter,
  output logic        boundary,
  output logic        frame_tick,
  output logic [2:0]  color_idx
);

  localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_STEP - 1);

  logic [FC_W-1:0] frame_cnt;

  assign boundary = (hCount == 11'd0) && (vCount == 11'(V_ACTIVE));

  // Entering cycle mode restarts the sequence so it always begins on WHITE.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
      color_idx  <= '0;
    end else begin
      frame_tick <= boundary;
      if (boundary) begin
        if (enter) begin
          frame_cnt <= '0;
          color_idx <= '0;
        end else if (run) begin
          if (frame_cnt == FC_LAST) begin
            frame_cnt <= '0;
            color_idx <= color_idx + 3'd1;
          end else begin
            frame_cnt <= frame_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator: solid / bars / checker / cycle, registered output, frame-aligned mode switch.
// Define VGA_PATTERN_BORDER_EN to draw a white one-pixel border around the visible area.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE        = 640,
  parameter int V_ACTIVE        = 480,
  parameter int COLOR_W         = PIX_W,
  parameter int BAR_W           = 80,
  parameter int CHK_LOG2        = 4,
  parameter int FRAMES_PER_STEP = 60
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [10:0]        hCount,
  input  logic [10:0]        vCount,
  input  logic               blank,
  input  logic [1:0]         mode_req,
  input  logic [COLOR_W-1:0] solid_color,
  output logic [COLOR_W-1:0] rgb,
  output logic [1:0]         mode_active,
  output logic               frame_tick
);

  logic [1:0]  mode_q;
  logic        boundary;
  logic        run;
  logic        enter;
  logic [2:0]  color_idx;
  logic [10:0] bar_raw;
  logic [2:0]  bar_idx;
  logic        visible;
  logic [COLOR_W-1:0] pattern;
  logic [COLOR_W-1:0] pix_next;

  assign mode_active = mode_q;
  assign run   = (mode_q == MODE_CYCLE);
  assign enter = (mode_q != MODE_CYCLE) && (mode_req == MODE_CYCLE);

  vga_frame_stepper #(
    .V_ACTIVE        (V_ACTIVE),
    .FRAMES_PER_STEP (FRAMES_PER_STEP)
  ) u_stepper (
    .clk        (clk),
    .reset      (reset),
    .hCount     (hCount),
    .vCount     (vCount),
    .run        (run),
    .enter      (enter),
    .boundary   (boundary),
    .frame_tick (frame_tick),
    .color_idx  (color_idx)
  );

  // Mode only moves on the boundary pixel, which is blanked, so no frame mixes patterns.
  always_ff @(posedge clk) begin
    if (reset)         mode_q <= MODE_SOLID;
    else if (boundary) mode_q <= mode_req;
  end

  always_comb begin
    bar_raw = hCount / 11'(BAR_W);
    bar_idx = (bar_raw > 11'd7) ? 3'd7 : bar_raw[2:0];
    visible = !blank && (hCount < 11'(H_ACTIVE)) && (vCount < 11'(V_ACTIVE));

    pattern = '0;
    case (mode_q)
      MODE_SOLID: pattern = solid_color;
      MODE_BARS:  pattern = COLOR_W'(PALETTE[bar_idx]);
      MODE_CHECK: pattern = (hCount[CHK_LOG2] ^ vCount[CHK_LOG2]) ? solid_color : '0;
      default:    pattern = COLOR_W'(PALETTE[color_idx]);
    endcase

`ifdef VGA_PATTERN_BORDER_EN
    if ((hCount == 11'd0) || (hCount == 11'(H_ACTIVE - 1)) ||
        (vCount == 11'd0) || (vCount == 11'(V_ACTIVE - 1)))
      pattern = '1;
`endif

    pix_next = visible ? pattern : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) rgb <= '0;
    else       rgb <= pix_next;
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomized self-checking bench for vga_pattern_gen against a frame-level reference model.
module tb_vga_pattern_gen;

  localparam int FPS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] hCount = '0;
  logic [10:0] vCount = '0;
  logic        blank = 1'b1;
  logic [1:0]  mode_req = '0;
  logic [11:0] solid_color = '0;
  logic [11:0] rgb;
  logic [1:0]  mode_active;
  logic        frame_tick;

  vga_pattern_gen #(
    .H_ACTIVE        (640),
    .V_ACTIVE        (480),
    .COLOR_W         (12),
    .BAR_W           (80),
    .CHK_LOG2        (4),
    .FRAMES_PER_STEP (FPS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hCount      (hCount),
    .vCount      (vCount),
    .blank       (blank),
    .mode_req    (mode_req),
    .solid_color (solid_color),
    .rgb         (rgb),
    .mode_active (mode_active),
    .frame_tick  (frame_tick)
  );

  always #20 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference state: mode in force and boundaries seen since cycle mode was entered.
  int m_mode  = 0;
  int m_ticks = 0;
  logic [11:0] pal [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int h, input int v, input bit b, input int mr, input int sc, input bit rst);
    logic [11:0] e_rgb;
    bit bnd;
    int bi;
    reset       = rst;
    hCount      = 11'(h);
    vCount      = 11'(v);
    blank       = b;
    mode_req    = 2'(mr);
    solid_color = 12'(sc);
    bnd = (h == 0) && (v == 480);
    if (rst || b || h >= 640 || v >= 480) e_rgb = 12'h000;
    else begin
      case (m_mode)
        0: e_rgb = 12'(sc);
        1: begin bi = h / 80; if (bi > 7) bi = 7; e_rgb = pal[bi]; end
        2: e_rgb = (((h / 16) + (v / 16)) % 2 == 1) ? 12'(sc) : 12'h000;
        default: e_rgb = pal[(m_ticks / FPS) % 8];
      endcase
`ifdef VGA_PATTERN_BORDER_EN
      if (h == 0 || h == 639 || v == 0 || v == 479) e_rgb = 12'hFFF;
`endif
    end
    if (rst) begin
      m_mode = 0; m_ticks = 0;
    end else if (bnd) begin
      if (m_mode != 3 && mr == 3) m_ticks = 0;
      else if (m_mode == 3)       m_ticks++;
      m_mode = mr;
    end
    @(posedge clk);
    #1;
    chk("rgb",  32'(rgb),         32'(e_rgb));
    chk("mode", 32'(mode_active), 32'(m_mode));
    chk("tick", 32'(frame_tick),  32'(!rst && bnd));
  endtask

  // Random pixel away from the boundary; occasionally disagree with blank to hit out-of-range/forced blank.
  task automatic rand_px(input int mr, input int sc);
    int h, v;
    bit b;
    h = int'($urandom_range(0, 799));
    v = int'($urandom_range(0, 524));
    if (h == 0 && v == 480) h = 1;
    b = (h >= 640 || v >= 480);
    if ($urandom_range(0, 7) == 0) b = !b;
    step(h, v, b, mr, sc, 1'b0);
  endtask

  task automatic frame_end(input int mr, input int sc);
    step(0, 480, 1'b1, mr, sc, 1'b0);
  endtask

  initial begin
    // Reset held mid-line with a non-solid request; mode must stay solid until a boundary.
    for (int i = 0; i < 3; i++) step(5, 100, 1'b0, 2, 12'hABC, 1'b1);
    for (int i = 0; i < 20; i++) rand_px(2, 12'hABC);

    frame_end(0, 12'hFF0);
    step(0, 0, 1'b0, 0, 12'hFF0, 1'b0);
    step(639, 479, 1'b0, 0, 12'hFF0, 1'b0);
    step(639, 479, 1'b1, 0, 12'hFF0, 1'b0);
    for (int i = 0; i < 300; i++) rand_px(0, 12'hFF0);

    frame_end(1, 12'h123);
    step(79, 10, 1'b0, 1, 0, 1'b0);
    step(80, 10, 1'b0, 1, 0, 1'b0);
    step(639, 10, 1'b0, 1, 0, 1'b0);
    step(400, 200, 1'b0, 1, 0, 1'b0);
    step(700, 200, 1'b0, 1, 0, 1'b0);
    for (int i = 0; i < 300; i++) rand_px(1, int'($urandom_range(0, 4095)));

    frame_end(2, 12'h0F0);
    step(15, 0, 1'b0, 2, 12'h0F0, 1'b0);
    step(16, 0, 1'b0, 2, 12'h0F0, 1'b0);
    step(16, 16, 1'b0, 2, 12'h0F0, 1'b0);
    step(31, 47, 1'b0, 2, 12'h0F0, 1'b0);
    for (int i = 0; i < 300; i++) rand_px(2, 12'h0F0);

    // Request toggles within a frame must not disturb the active mode.
    for (int i = 0; i < 10; i++) rand_px(1, 12'h0F0);
    for (int i = 0; i < 10; i++) rand_px(2, 12'h0F0);
    for (int i = 0; i < 10; i++) rand_px(1, 12'h0F0);
    frame_end(1, 12'h0F0);
    for (int i = 0; i < 50; i++) rand_px(1, 12'h0F0);

    frame_end(3, 12'h555);
    for (int f = 0; f < 18; f++) begin
      step(320, 240, 1'b0, 3, 12'h555, 1'b0);
      for (int i = 0; i < 30; i++) rand_px(3, int'($urandom_range(0, 4095)));
      frame_end(3, 12'h555);
    end
    step(320, 240, 1'b0, 3, 12'h555, 1'b0);

    // Mid-frame reset while cycling clears mode and counters.
    step(100, 100, 1'b0, 3, 12'h555, 1'b1);
    for (int i = 0; i < 20; i++) rand_px(3, 12'h555);
    frame_end(3, 12'h555);
    step(320, 240, 1'b0, 3, 12'h555, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) frame_end(int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
      else rand_px(int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
